// File: rtl/animation_sprite_draw_pkg.sv
// Shared constants for the intro-animation character sprites.
package animation_sprite_draw_pkg;

  localparam int DONKEY_SPRITE_W      = 48;
  localparam int DONKEY_SPRITE_H      = 48;
  localparam int DONKEY_SPRITE_FRAMES = 2;
  localparam int DONKEY_FRAME_DIV     = 8;

  localparam logic [11:0] SPRITE_KEY_COLOR = 12'hF0F;

  // VGA timing bundle carried down the overlay pipeline
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_timing_t;

  // Counter width able to hold 0..n-1 (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/animation_sprite_draw_delay.sv
// Generic N-stage register chain of width W with synchronous reset.
module animation_sprite_draw_delay #(
  parameter int unsigned N = 1,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [N];

  // Shift din through N registers, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int unsigned i = 1; i < N; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[N-1];

endmodule

// File: rtl/animation_sprite_draw.sv
// Donkey sprite overlay stage for the intro animation.
// Position/visibility are latched at vblank start; pixels come from an
// external synchronous ROM. Three-clock latency on all video outputs.
// Optional: define ANIM_SPRITE_BBOX_EN to draw a white 1-pixel debug outline
// around the sprite box while it is shown.
module animation_sprite_draw
  import animation_sprite_draw_pkg::*;
#(
  parameter int          SPRITE_W  = DONKEY_SPRITE_W,
  parameter int          SPRITE_H  = DONKEY_SPRITE_H,
  parameter int          FRAMES    = DONKEY_SPRITE_FRAMES,
  parameter int          FRAME_DIV = DONKEY_FRAME_DIV,
  parameter logic [11:0] KEY_COLOR = SPRITE_KEY_COLOR,
  parameter int          ADDR_W    = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              animation,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out,
  output logic              done
);

  localparam int FR_W  = cnt_width(FRAMES);
  localparam int DIV_W = cnt_width(FRAME_DIV);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_HIDDEN = 2'd2
  } state_t;

  state_t             state;
  logic               vblnk_d;
  logic               frame_edge;
  logic [11:0]        xpos_l;
  logic [11:0]        ypos_l;
  logic               anim_l;
  logic [DIV_W-1:0]   frame_cnt;
  logic [FR_W-1:0]    sprite_frame;

  assign frame_edge = vblnk_in & ~vblnk_d;

  // Per-frame control: latch position, run visibility FSM and frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d      <= 1'b0;
      state        <= ST_WAIT;
      xpos_l       <= '0;
      ypos_l       <= '0;
      anim_l       <= 1'b0;
      frame_cnt    <= '0;
      sprite_frame <= '0;
      done         <= 1'b0;
    end else begin
      vblnk_d <= vblnk_in;
      done    <= 1'b0;
      if (frame_edge) begin
        xpos_l <= xpos;
        ypos_l <= ypos;
        anim_l <= animation;
      end
      case (state)
        ST_WAIT: begin
          if (frame_edge) state <= animation ? ST_SHOW : ST_HIDDEN;
        end
        ST_SHOW: begin
          if (frame_edge) begin
            if (!animation) begin
              state <= ST_HIDDEN;
              done  <= 1'b1;
            end else if (frame_cnt == DIV_W'(FRAME_DIV - 1)) begin
              frame_cnt    <= '0;
              sprite_frame <= (sprite_frame == FR_W'(FRAMES - 1)) ? '0
                                                                    : sprite_frame + FR_W'(1);
            end else begin
              frame_cnt <= frame_cnt + DIV_W'(1);
            end
          end
        end
        ST_HIDDEN: begin
          if (frame_edge && animation) begin
            state        <= ST_SHOW;
            frame_cnt    <= '0;
            sprite_frame <= '0;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  // Stage 1 combinational: box test on offsets so a box past the screen edge clips
  logic [11:0]       dx;
  logic [11:0]       dy;
  logic              in_box_c;
  logic [ADDR_W-1:0] addr_c;

  // Box membership and ROM address for the current pixel
  always_comb begin
    dx       = {1'b0, hcount_in} - xpos_l;
    dy       = {1'b0, vcount_in} - ypos_l;
    in_box_c = (state == ST_SHOW) && anim_l
            && ({1'b0, hcount_in} >= xpos_l) && (dx < 12'(SPRITE_W))
            && ({1'b0, vcount_in} >= ypos_l) && (dy < 12'(SPRITE_H));
    addr_c   = '0;
    if (in_box_c)
      addr_c = ADDR_W'(sprite_frame) * ADDR_W'(SPRITE_W * SPRITE_H)
             + ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx);
  end

  logic in_box_d1;
  logic in_box_d2;

  // Stage 1/2 registers: ROM address and box flag alongside the ROM read
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
    end else begin
      rom_addr  <= addr_c;
      in_box_d1 <= in_box_c;
      in_box_d2 <= in_box_d1;
    end
  end

  vga_timing_t timing_in;
  vga_timing_t timing_out;
  logic [11:0] rgb_d2;

  assign timing_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                       vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  animation_sprite_draw_delay #(.N(3), .W($bits(vga_timing_t))) u_timing_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (timing_in),
    .dout (timing_out)
  );

  animation_sprite_draw_delay #(.N(2), .W(12)) u_rgb_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (rgb_in),
    .dout (rgb_d2)
  );

  assign hcount_out = timing_out.hcount;
  assign vcount_out = timing_out.vcount;
  assign hsync_out  = timing_out.hsync;
  assign vsync_out  = timing_out.vsync;
  assign hblnk_out  = timing_out.hblnk;
  assign vblnk_out  = timing_out.vblnk;

  logic [11:0] rgb_next;

`ifdef ANIM_SPRITE_BBOX_EN
  logic border_c;
  logic border_d1;
  logic border_d2;

  assign border_c = in_box_c && ((dx == '0) || (dx == 12'(SPRITE_W - 1))
                              || (dy == '0) || (dy == 12'(SPRITE_H - 1)));

  // Outline flag follows the same two-stage path as the box flag
  always_ff @(posedge clk) begin
    if (rst) begin
      border_d1 <= 1'b0;
      border_d2 <= 1'b0;
    end else begin
      border_d1 <= border_c;
      border_d2 <= border_d1;
    end
  end

  // Compose: outline over sprite over background
  always_comb begin
    rgb_next = rgb_d2;
    if (border_d2)
      rgb_next = 12'hFFF;
    else if (in_box_d2 && (rom_data != KEY_COLOR))
      rgb_next = rom_data;
  end
`else
  // Compose: opaque sprite pixels over background
  always_comb begin
    rgb_next = rgb_d2;
    if (in_box_d2 && (rom_data != KEY_COLOR))
      rgb_next = rom_data;
  end
`endif

  // Stage 3 output register
  always_ff @(posedge clk) begin
    if (rst) rgb_out <= '0;
    else     rgb_out <= rgb_next;
  end

endmodule

// File: doc/animation_sprite_draw.md
Name: animation_sprite_draw

Overview:
- Consumer end of the intro-animation position interface. Overlays the animated Donkey sprite onto the VGA pixel stream at the position supplied by the animation controller (animation, xpos, ypos).
- Position and visibility are sampled once per frame, at vblank start, so there is no tearing.
- Alternates sprite frames on a frame-count basis and reads pixels from an external synchronous sprite ROM.
- Sits between the background draw stage and the next overlay stage in the VGA chain.

Parameters:
- SPRITE_W, 48, sprite width in pixels.
- SPRITE_H, 48, sprite height in pixels.
- FRAMES, 2, number of sprite frames stored consecutively in ROM.
- FRAME_DIV, 8, number of displayed video frames per sprite frame.
- KEY_COLOR, 12'hF0F, transparent colour in ROM data.
- ADDR_W, 13, ROM address width; must satisfy 2^ADDR_W >= FRAMES*SPRITE_W*SPRITE_H.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- animation  in  1  sprite visible request from the animation controller.
- xpos  in  12  sprite top-left x.
- ypos  in  12  sprite top-left y.
- hcount_in, vcount_in  in  11  VGA counters.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1  VGA timing.
- rgb_in  in  12  upstream pixel.
- rom_addr  out  ADDR_W  sprite ROM address (registered).
- rom_data  in  12  ROM pixel, valid one clk after rom_addr.
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  timing delayed 3 clk.
- rgb_out  out  12  composed pixel.
- done  out  1  single-cycle pulse when the sprite is hidden after having been shown.

Behaviour:
- Reset: every output 0, state ST_WAIT, latched position 0, frame_cnt 0, sprite_frame 0.
- Frame edge: vblnk_in=1 and vblnk_d=0, where vblnk_d is vblnk_in registered.
- At a frame edge:
  - xpos_l <= xpos, ypos_l <= ypos, anim_l <= animation.
  - xpos/ypos changes between frame edges are ignored.
- State machine:
  - ST_WAIT: on frame edge go to ST_SHOW if animation=1, else ST_HIDDEN.
  - ST_SHOW: on frame edge with animation=0, go to ST_HIDDEN and pulse done=1 for that cycle. Otherwise stay.
  - ST_HIDDEN: on frame edge with animation=1, go to ST_SHOW with frame_cnt=0 and sprite_frame=0. No done pulse.
  - Non-frame-edge cycles hold state.
  - Illegal encoding goes to ST_WAIT.
- Frame counter, only in ST_SHOW:
  - Each frame edge increments frame_cnt.
  - At FRAME_DIV-1: frame_cnt wraps to 0 and sprite_frame increments, wrapping at FRAMES-1 to 0.
- Stage 1, registered:
  - in_box = (state==ST_SHOW) and hcount in [xpos_l, xpos_l+SPRITE_W-1] and vcount in [ypos_l, ypos_l+SPRITE_H-1].
  - All comparisons are 12-bit unsigned, so a box crossing the screen edge simply clips. No wrap.
  - rom_addr = sprite_frame*SPRITE_W*SPRITE_H + (vcount-ypos_l)*SPRITE_W + (hcount-xpos_l), computed only when in_box, else 0.
- Stage 2: delay timing, rgb and in_box one more clk while the ROM reads.
- Stage 3: rgb_out = rom_data if in_box_d2=1 and rom_data != KEY_COLOR, else rgb_d2.
- Latency: all *_out are exactly 3 clk after the matching inputs. rom_addr is 1 clk after its inputs.
- Reset mid-frame: pipeline clears to 0. The sprite is not drawn until the first frame edge after reset.

Optional Feature:
- Macro: ANIM_SPRITE_BBOX_EN.
- Defined: pixels on the 1-pixel border of the box, while in ST_SHOW, are forced to 12'hFFF regardless of ROM data or key. This is a debug outline.
- Undefined: there is no border logic and the output is purely sprite/background.

Decomposition:
- characterPkg gains DONKEY_SPRITE_W/H, DONKEY_SPRITE_FRAMES, DONKEY_FRAME_DIV and SPRITE_KEY_COLOR; the parameter defaults reference these.
- The state enum is local to the module.
- One natural sub-module: delay, a generic N-stage register chain of width W with synchronous reset, used for the timing/rgb signals.

Test Plan:
1. After reset, animation=1, xpos=484, ypos=672, first frame edge → ST_SHOW. The pixel at hcount=484, vcount=672 yields rom_addr=0 one clk later and rgb_out=rom_data 3 clk after the input.
2. Pixel at hcount=531, vcount=719 with sprite_frame=0 → rom_addr=2303. Pixel at hcount=532 → outside the box, rgb_out=rgb_in delayed 3 clk.
3. rom_data=12'hF0F inside the box → rgb_out equals the background. rom_data=12'h0A0 → rgb_out=12'h0A0.
4. Change ypos from 175 to 160 mid-frame → drawing keeps ypos 175 until the next vblank edge, then uses 160.
5. Eight frame edges in ST_SHOW → sprite_frame 0→1, rom_addr base 2304. Sixteen edges → back to 0.
6. Drop animation to 0 mid-frame → sprite still drawn until the next frame edge. Then done is high for exactly 1 clk, and rgb_out equals rgb_in delayed for the whole next frame.
